// File: rtl/can_tx_arbiter_if.sv
// Requester-side and CAN-transmitter-side handshake bundle for can_tx_arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic's view.
interface can_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    grant;
  logic [31:0]           tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic                  tx_done;
  logic                  tx_error;

  modport master (
    input  req, req_data, tx_busy, tx_done, tx_error,
    output grant, tx_data, tx_start
  );

  modport slave (
    output req, req_data, tx_busy, tx_done, tx_error,
    input  grant, tx_data, tx_start
  );
endinterface

// File: rtl/can_tx_arbiter.sv
// Shares one CAN transmitter among NUM_REQ frame sources by lowest-ID priority, with retry/drop.
// Optional starvation aging is enabled by defining CAN_TX_ARB_AGING_EN.
module can_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_RETRY = 3,
  parameter int AGE_LIMIT = 7
) (
  input  logic                 clk,
  input  logic                 n_rst,
  can_tx_arbiter_if.master     bus,
  output logic                 drop_err,
  output logic [7:0]           drop_count,
  output logic                 arb_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT_DONE,
    DROP
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   win_idx;
  logic [15:0]     best_id;
  logic            found;
  logic            any_req;
  logic [31:0]     frame_q;
  logic [RW-1:0]   retry_cnt;

  assign any_req = |bus.req;

`ifdef CAN_TX_ARB_AGING_EN
  localparam int AW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

  logic [AW-1:0] age [NUM_REQ];
  logic          old_found;
`endif

  // Strict '<' keeps the earlier index on an ID tie; a starved requester overrides the ID result.
  always_comb begin
    win_idx = '0;
    best_id = 16'hFFFF;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i] && (!found || (bus.req_data[32*i+16 +: 16] < best_id))) begin
        win_idx = IW'(i);
        best_id = bus.req_data[32*i+16 +: 16];
        found   = 1'b1;
      end
    end
`ifdef CAN_TX_ARB_AGING_EN
    old_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i] && (age[i] == AGE_MAX) && !old_found) begin
        win_idx   = IW'(i);
        old_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = ARB;
      ARB:       state_nxt = any_req ? LAUNCH : IDLE;
      LAUNCH:    if (!bus.tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.tx_done) begin
          state_nxt = IDLE;
        end else if (bus.tx_error) begin
          state_nxt = (retry_cnt == RETRY_MAX) ? DROP : LAUNCH;
        end
      end
      DROP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.grant = '0;
    if ((state == ARB) && any_req) begin
      bus.grant[win_idx] = 1'b1;
    end
  end

  assign bus.tx_start = (state == LAUNCH) && !bus.tx_busy;
  assign bus.tx_data  = frame_q;
  assign drop_err     = (state == DROP);
  assign arb_busy     = (state != IDLE);

  // frame_q is only loaded in ARB, so retries always resend the identical word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      frame_q    <= 32'hFFFF_FFFF;
      retry_cnt  <= '0;
      drop_count <= 8'd0;
    end else begin
      state <= state_nxt;
      if ((state == ARB) && any_req) begin
        frame_q <= bus.req_data[32*win_idx +: 32];
      end
      if (state == WAIT_DONE) begin
        if (bus.tx_done) begin
          retry_cnt <= '0;
        end else if (bus.tx_error && (retry_cnt != RETRY_MAX)) begin
          retry_cnt <= retry_cnt + 1'b1;
        end
      end
      if (state == DROP) begin
        retry_cnt <= '0;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

`ifdef CAN_TX_ARB_AGING_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_REQ; i++) age[i] <= '0;
    end else if (state == ARB) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req[i] || (i == int'(win_idx))) begin
          age[i] <= '0;
        end else if (age[i] != AGE_MAX) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Scoreboard bench for can_tx_arbiter: directed frames push expected grant/launch/drop events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_can_tx_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int MAX_RETRY = 3;
  localparam int AGE_LIMIT = 7;

  typedef enum int {EV_GRANT = 0, EV_START = 1, EV_DROP = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       drop_err;
  logic [7:0] drop_count;
  logic       arb_busy;

  int  n_cmp = 0;
  int  n_err = 0;
  ev_t sb[$];

  can_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  can_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MAX_RETRY(MAX_RETRY),
    .AGE_LIMIT(AGE_LIMIT)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus),
    .drop_err(drop_err),
    .drop_count(drop_count),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input ev_kind_t kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input ev_kind_t kind, input logic [31:0] val, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s: unexpected event value %h, expected no event at %0t", name, val, $time);
    end else begin
      e = sb.pop_front();
      checkOutput({name, "_kind"}, 32'(kind), 32'(e.kind));
      checkOutput(name, val, e.val);
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (bus.grant != '0) sb_pop(EV_GRANT, 32'(bus.grant), "grant");
        if (bus.tx_start)    sb_pop(EV_START, bus.tx_data, "tx_start_data");
        if (drop_err)        sb_pop(EV_DROP, bus.tx_data, "drop_data");
      end
    end
  end

  task automatic wait_for(input int kind, input string name, output int cycles);
    bit hit;
    cycles = 0;
    hit = (kind == 0) ? (bus.grant != '0) : bus.tx_start;
    while (!hit && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      hit = (kind == 0) ? (bus.grant != '0) : bus.tx_start;
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s: timeout after %0d cycles, expected event", name, cycles);
    end
  endtask

  // Drives a request set, queues its grant and first launch, returns one cycle after ARB.
  task automatic applyStimulus(input logic [1:0] req, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] exp_grant, input logic [31:0] exp_frame,
                               input bit hold_req, output int lat_grant);
    sb_push(EV_GRANT, 32'(exp_grant));
    sb_push(EV_START, exp_frame);
    bus.req_data = {d1, d0};
    bus.req      = req;
    wait_for(0, "wait_grant", lat_grant);
    @(posedge clk); #1;
    if (!hold_req) bus.req = '0;
  endtask

  task automatic finish_ok(input bit with_err);
    @(posedge clk); #1;
    bus.tx_done  = 1'b1;
    bus.tx_error = with_err;
    @(posedge clk); #1;
    bus.tx_done  = 1'b0;
    bus.tx_error = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lg, ls, starts;
    logic [1:0] exp_g;

    n_rst        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;
    bus.tx_error = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("rst_drop_err", 32'(drop_err), 32'd0);
    checkOutput("rst_drop_count", 32'(drop_count), 32'd0);
    checkOutput("rst_arb_busy", 32'(arb_busy), 32'd0);
    checkOutput("rst_tx_data", bus.tx_data, 32'hFFFF_FFFF);
    n_rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single requester, minimum latency");
    applyStimulus(2'b01, 32'h0123_AAAA, 32'h0, 2'b01, 32'h0123_AAAA, 1'b0, lg);
    wait_for(1, "wait_start", ls);
    checkOutput("latency_req_to_start", 32'(lg + 1 + ls), 32'd2);
    finish_ok(1'b0);
    checkOutput("idle_arb_busy", 32'(arb_busy), 32'd0);

    $display("[TB] lower ID wins, then index tie-break");
    applyStimulus(2'b11, 32'h0200_1111, 32'h0100_5555, 2'b10, 32'h0100_5555, 1'b0, lg);
    wait_for(1, "wait_start", ls);
    finish_ok(1'b0);
    applyStimulus(2'b11, 32'h0300_1111, 32'h0300_2222, 2'b01, 32'h0300_1111, 1'b0, lg);
    wait_for(1, "wait_start", ls);
    finish_ok(1'b0);

    $display("[TB] error on every attempt, retry then drop");
    applyStimulus(2'b10, 32'h0, 32'h0456_BEEF, 2'b10, 32'h0456_BEEF, 1'b0, lg);
    for (int a = 0; a < MAX_RETRY; a++) sb_push(EV_START, 32'h0456_BEEF);
    sb_push(EV_DROP, 32'h0456_BEEF);
    wait_for(1, "wait_start", ls);
    for (int a = 1; a <= MAX_RETRY + 1; a++) begin
      @(posedge clk); #1;
      bus.tx_error = 1'b1;
      @(posedge clk); #1;
      bus.tx_error = 1'b0;
      if (a <= MAX_RETRY) wait_for(1, "wait_retry_start", ls);
    end
    checkOutput("drop_err_pulse", 32'(drop_err), 32'd1);
    @(posedge clk); #1;
    checkOutput("drop_count_after_drop", 32'(drop_count), 32'd1);
    checkOutput("drop_err_cleared", 32'(drop_err), 32'd0);
    checkOutput("tx_data_after_drop", bus.tx_data, 32'h0456_BEEF);

    $display("[TB] transmitter busy, then done+error together");
    bus.tx_busy = 1'b1;
    applyStimulus(2'b01, 32'h0777_0001, 32'h0, 2'b01, 32'h0777_0001, 1'b0, lg);
    starts = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.tx_start) starts++;
      @(posedge clk); #1;
    end
    checkOutput("no_start_while_busy", 32'(starts), 32'd0);
    bus.tx_busy = 1'b0;
    #1;
    checkOutput("start_when_busy_falls", 32'(bus.tx_start), 32'd1);
    finish_ok(1'b1);
    checkOutput("done_err_drop_count", 32'(drop_count), 32'd1);
    checkOutput("done_err_arb_busy", 32'(arb_busy), 32'd0);

    $display("[TB] reset during WAIT_DONE");
    applyStimulus(2'b01, 32'h0888_0002, 32'h0, 2'b01, 32'h0888_0002, 1'b0, lg);
    wait_for(1, "wait_start", ls);
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    checkOutput("async_rst_tx_data", bus.tx_data, 32'hFFFF_FFFF);
    checkOutput("async_rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("async_rst_drop_count", 32'(drop_count), 32'd0);
    checkOutput("async_rst_arb_busy", 32'(arb_busy), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    starts = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.tx_start) starts++;
    end
    checkOutput("no_start_after_reset", 32'(starts), 32'd0);

    $display("[TB] held requests, aging behaviour");
    for (int k = 1; k <= AGE_LIMIT + 1; k++) begin
`ifdef CAN_TX_ARB_AGING_EN
      exp_g = (k == AGE_LIMIT + 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      applyStimulus(2'b11, {16'h0001, 16'(k)}, 32'h0002_CAFE, exp_g,
                    (exp_g == 2'b10) ? 32'h0002_CAFE : {16'h0001, 16'(k)}, 1'b1, lg);
      wait_for(1, "wait_start", ls);
      finish_ok(1'b0);
    end
    bus.req = '0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("final_arb_busy", 32'(arb_busy), 32'd0);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
